// File: rtl/complex_add_sub.sv
// Registered complex adder/subtractor for packed signed fixed-point operands.
// Word packing: [2W-1:W] = real, [W-1:0] = imag. One cycle of latency, with
// per-component overflow flags and an optional clamp to the W-bit range.
//
// Handshake: in_valid qualifies x, y and ctrl in the cycle it is high. The
// result appears with out_valid=1 in the following cycle. There is no ready
// and no backpressure, so every valid input is accepted. With in_valid=0,
// out and the ovf flags keep their last values and out_valid drops to 0.
module complex_add_sub #(
  parameter int W        = 8,
  parameter int SATURATE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [2*W-1:0] x,
  input  logic [2*W-1:0] y,
  input  logic           ctrl,
  output logic [2*W-1:0] out,
  output logic           out_valid,
  output logic           ovf_re,
  output logic           ovf_im
);

  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MAX_NEG = {1'b1, {(W-1){1'b0}}};

  logic signed [W:0] xr_ext, xi_ext, yr_ext, yi_ext;
  logic signed [W:0] re_full, im_full;
  logic              re_ovf, im_ovf;
  logic [W-1:0]      re_res, im_res;

  logic [2*W-1:0] out_d, out_q;
  logic           out_valid_d, out_valid_q;
  logic           ovf_re_d, ovf_re_q;
  logic           ovf_im_d, ovf_im_q;

  // Sign-extend each component to W+1 bits, then add or subtract independently
  // so no carry or borrow crosses from imag into real.
  always_comb begin
    xr_ext  = {x[2*W-1], x[2*W-1:W]};
    xi_ext  = {x[W-1],   x[W-1:0]};
    yr_ext  = {y[2*W-1], y[2*W-1:W]};
    yi_ext  = {y[W-1],   y[W-1:0]};
    re_full = ctrl ? (xr_ext + yr_ext) : (xr_ext - yr_ext);
    im_full = ctrl ? (xi_ext + yi_ext) : (xi_ext - yi_ext);
  end

  // The result is out of W-bit range exactly when its top two bits differ.
  // In that case the top bit is the true sign and picks the clamp value.
  always_comb begin
    re_ovf = re_full[W] ^ re_full[W-1];
    im_ovf = im_full[W] ^ im_full[W-1];
    re_res = re_full[W-1:0];
    im_res = im_full[W-1:0];
    if (SATURATE != 0) begin
      if (re_ovf) re_res = re_full[W] ? MAX_NEG : MAX_POS;
      if (im_ovf) im_res = im_full[W] ? MAX_NEG : MAX_POS;
    end
  end

  // Next-state for the output registers: load on a valid input, otherwise hold
  // the result and flags and drop out_valid.
  always_comb begin
    out_d       = out_q;
    ovf_re_d    = ovf_re_q;
    ovf_im_d    = ovf_im_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      out_d       = {re_res, im_res};
      ovf_re_d    = re_ovf;
      ovf_im_d    = im_ovf;
      out_valid_d = 1'b1;
    end
  end

  // Output registers. Reset wins over a valid input in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_re_q    <= 1'b0;
      ovf_im_q    <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ovf_re_q    <= ovf_re_d;
      ovf_im_q    <= ovf_im_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign ovf_re    = ovf_re_q;
  assign ovf_im    = ovf_im_q;

endmodule

// File: tb/tb_complex_add_sub.sv
// Directed bench for complex_add_sub at W=8. A wrapping and a saturating
// instance share the same stimulus. Inputs change on the falling edge, and
// outputs are sampled on the following falling edge.
module tb_complex_add_sub;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] x, y;
  logic        ctrl;

  logic [15:0] out_w, out_s;
  logic        vld_w, vld_s, ore_w, ore_s, oim_w, oim_s;

  int checks;
  int errors;

  logic [15:0] exp_q[$];

  complex_add_sub #(.W(8), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .y(y), .ctrl(ctrl),
    .out(out_w), .out_valid(vld_w), .ovf_re(ore_w), .ovf_im(oim_w)
  );

  complex_add_sub #(.W(8), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .y(y), .ctrl(ctrl),
    .out(out_s), .out_valid(vld_s), .ovf_re(ore_s), .ovf_im(oim_s)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present one valid sample, then wait to the sampling edge
  task automatic drive(input logic [15:0] vx, input logic [15:0] vy, input logic vc);
    @(negedge clk);
    in_valid = 1'b1; x = vx; y = vy; ctrl = vc;
    @(negedge clk);
    in_valid = 1'b0; x = 16'hxxxx; y = 16'hxxxx; ctrl = 1'bx;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; ctrl = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({out_w, vld_w, ore_w, oim_w} !== 19'h0) begin
      errors++; $display("FAIL reset_wrap got=%h exp=0", {out_w, vld_w, ore_w, oim_w});
    end
    checks++;
    if ({out_s, vld_s, ore_s, oim_s} !== 19'h0) begin
      errors++; $display("FAIL reset_sat got=%h exp=0", {out_s, vld_s, ore_s, oim_s});
    end
  endtask

  task automatic test_add();
    drive(16'h0402, 16'h0306, 1'b1);
    checks++;
    if ({out_w, vld_w, ore_w, oim_w} !== {16'h0708, 3'b100}) begin
      errors++; $display("FAIL add got=%h v=%b f=%b%b exp=0708 v=1 f=00", out_w, vld_w, ore_w, oim_w);
    end
  endtask

  task automatic test_sub();
    drive(16'h0402, 16'h0306, 1'b0);
    checks++;
    if ({out_w, vld_w, ore_w, oim_w} !== {16'h01FC, 3'b100}) begin
      errors++; $display("FAIL sub got=%h v=%b f=%b%b exp=01fc v=1 f=00", out_w, vld_w, ore_w, oim_w);
    end
  endtask

  task automatic test_wrap();
    // 127+1 overflows real; -128+1 = -127 is fine
    drive(16'h7F80, 16'h0101, 1'b1);
    checks++;
    if ({out_w, vld_w, ore_w, oim_w} !== {16'h8081, 3'b110}) begin
      errors++; $display("FAIL wrap_add got=%h v=%b f=%b%b exp=8081 v=1 f=10", out_w, vld_w, ore_w, oim_w);
    end
    checks++;
    if ({out_s, ore_s, oim_s} !== {16'h7F81, 2'b10}) begin
      errors++; $display("FAIL wrap_add_sat got=%h f=%b%b exp=7f81 f=10", out_s, ore_s, oim_s);
    end
    // imag: -128-1 = -129 wraps to 0x7F; real 0-0 = 0
    drive(16'h0080, 16'h0001, 1'b0);
    checks++;
    if ({out_w, vld_w, ore_w, oim_w} !== {16'h007F, 3'b101}) begin
      errors++; $display("FAIL wrap_sub got=%h v=%b f=%b%b exp=007f v=1 f=01", out_w, vld_w, ore_w, oim_w);
    end
    checks++;
    if ({out_s, ore_s, oim_s} !== {16'h0080, 2'b01}) begin
      errors++; $display("FAIL wrap_sub_sat got=%h f=%b%b exp=0080 f=01", out_s, ore_s, oim_s);
    end
  endtask

  task automatic test_saturate();
    drive(16'h7F80, 16'h017F, 1'b1);
    checks++;
    if ({out_s, vld_s, ore_s, oim_s} !== {16'h7FFF, 3'b110}) begin
      errors++; $display("FAIL sat_add got=%h v=%b f=%b%b exp=7fff v=1 f=10", out_s, vld_s, ore_s, oim_s);
    end
    checks++;
    if ({out_w, ore_w, oim_w} !== {16'h80FF, 2'b10}) begin
      errors++; $display("FAIL sat_add_wrap got=%h f=%b%b exp=80ff f=10", out_w, ore_w, oim_w);
    end
    // 0 - (-128) overflows both components
    drive(16'h0000, 16'h8080, 1'b0);
    checks++;
    if ({out_s, vld_s, ore_s, oim_s} !== {16'h7F7F, 3'b111}) begin
      errors++; $display("FAIL sat_negmin got=%h v=%b f=%b%b exp=7f7f v=1 f=11", out_s, vld_s, ore_s, oim_s);
    end
    checks++;
    if ({out_w, ore_w, oim_w} !== {16'h8080, 2'b11}) begin
      errors++; $display("FAIL sat_negmin_wrap got=%h f=%b%b exp=8080 f=11", out_w, ore_w, oim_w);
    end
    // Negative overflow clamps to -128: -128 + -1
    drive(16'h8080, 16'hFFFF, 1'b1);
    checks++;
    if ({out_s, ore_s, oim_s} !== {16'h8080, 2'b11}) begin
      errors++; $display("FAIL sat_neg got=%h f=%b%b exp=8080 f=11", out_s, ore_s, oim_s);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vx[4];
    logic [15:0] vy[4];
    logic        vc[4];
    logic [15:0] exp;
    logic [15:0] last;
    vx = '{16'h0402, 16'h1020, 16'hF0FE, 16'h0A05};
    vy = '{16'h0306, 16'h0510, 16'h0203, 16'h0C07};
    vc = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_q.push_back(16'h0708);
    exp_q.push_back(16'h0B10);
    exp_q.push_back(16'hF201);
    exp_q.push_back(16'hFEFE);
    last = 16'hFEFE;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; x = vx[i]; y = vy[i]; ctrl = vc[i];
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if ({out_w, vld_w, ore_w, oim_w} !== {exp, 3'b100}) begin
        errors++; $display("FAIL stream[%0d] got=%h v=%b f=%b%b exp=%h v=1 f=00", i, out_w, vld_w, ore_w, oim_w, exp);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({out_w, vld_w} !== {last, 1'b0}) begin
        errors++; $display("FAIL hold[%0d] got=%h v=%b exp=%h v=0", i, out_w, vld_w, last);
      end
    end
  endtask

  task automatic test_reset_priority();
    drive(16'h0F0F, 16'h0101, 1'b1);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; x = 16'h1111; y = 16'h2222; ctrl = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if ({out_w, vld_w, ore_w, oim_w} !== 19'h0) begin
      errors++; $display("FAIL rst_prio got=%h v=%b f=%b%b exp=0000 v=0 f=00", out_w, vld_w, ore_w, oim_w);
    end
    @(negedge clk);
    checks++;
    if ({out_w, vld_w} !== 17'h0) begin
      errors++; $display("FAIL rst_stale got=%h v=%b exp=0000 v=0", out_w, vld_w);
    end
    drive(16'h0102, 16'h0304, 1'b1);
    checks++;
    if ({out_w, vld_w, ore_w, oim_w} !== {16'h0406, 3'b100}) begin
      errors++; $display("FAIL rst_first got=%h v=%b exp=0406 v=1", out_w, vld_w);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_sub();
    test_wrap();
    test_saturate();
    test_back_to_back();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
